// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES request arbiter and its round-robin picker.
package aes_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int AES_TIMEOUT_DEF = 64;
  localparam int AES_GAP_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef struct packed {
    aes_blk_t data;
    aes_blk_t key;
  } job_t;

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Request, response and AES_top-side signals of the arbiter.
// slave = arbiter side; master = requesters, result consumer and AES_top.
interface aes_req_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0]                    req_ready;
  logic [N_REQ*aes_pkg::AES_BLK_W-1:0] req_data;
  logic [N_REQ*aes_pkg::AES_BLK_W-1:0] req_key;

  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [ID_W-1:0]                     rsp_id;
  logic [aes_pkg::AES_BLK_W-1:0]       rsp_data;
  logic                                rsp_timeout;

  logic                                core_en;
  logic [aes_pkg::AES_BLK_W-1:0]       core_data_in;
  logic [aes_pkg::AES_BLK_W-1:0]       core_key_in;
  logic [aes_pkg::AES_BLK_W-1:0]       core_data_out;
  logic                                core_data_out_valid;

  modport slave (
    input  req_valid, req_data, req_key, rsp_ready, core_data_out, core_data_out_valid,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
           core_en, core_data_in, core_key_in
  );

  modport master (
    output req_valid, req_data, req_key, rsp_ready, core_data_out, core_data_out_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
           core_en, core_data_in, core_key_in
  );

endinterface

// File: rtl/aes_rr_picker.sv
// Combinational round-robin selector: first set req after ptr, with wrap; zero latency.
// AES_ARB_PRIORITY_EN: req[0] wins outright whenever set, the rest stay round-robin.
module aes_rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any
);

  logic            found;
  logic [ID_W-1:0] sel;

  assign any = |req;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
`ifdef AES_ARB_PRIORITY_EN
    if (req[0]) begin
      found = 1'b1;
    end
`endif
    // Search starts one past the last winner so the previous grantee goes last.
    for (int i = 1; i <= N_REQ; i++) begin
      sel = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[sel]) begin
        grant = sel;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES_top among N_REQ requesters; AES_ARB_PRIORITY_EN gives requester 0 absolute priority.
// Grant->core_en next cycle, result one cycle after core valid; an unaccepted result stalls all requesters.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = AES_TIMEOUT_DEF,
  parameter int GAP_CYCLES = AES_GAP_DEF
) (
  input logic              AES_clk,
  input logic              AES_rst,
  aes_req_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  job_id;
  logic             pick_any;
  job_t             job;
  aes_blk_t         rsp_dat;
  logic             rsp_tmo;
  logic [CNT_W-1:0] run_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             run_tmo;
  logic             gap_done;

  aes_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_id),
    .any   (pick_any)
  );

  assign run_tmo  = (run_cnt == CNT_W'(TIMEOUT - 1));
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  assign bus.core_data_in = job.data;
  assign bus.core_key_in  = job.key;
  assign bus.rsp_id       = job_id;
  assign bus.rsp_data     = rsp_dat;
  assign bus.rsp_timeout  = rsp_tmo;

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.core_en   = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = RUN;
          // No capture happens under reset, so the strobe must not promise one.
          if (!AES_rst) begin
            bus.req_ready[pick_id] = 1'b1;
          end
        end
      end
      RUN: begin
        bus.core_en = 1'b1;
        if (bus.core_data_out_valid || run_tmo) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      rr_ptr  <= ID_W'(N_REQ - 1);
      job_id  <= '0;
      job     <= '0;
      rsp_dat <= '0;
      rsp_tmo <= 1'b0;
      run_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            rr_ptr   <= pick_id;
            job_id   <= pick_id;
            job.data <= bus.req_data[int'(pick_id)*AES_BLK_W +: AES_BLK_W];
            job.key  <= bus.req_key[int'(pick_id)*AES_BLK_W +: AES_BLK_W];
            run_cnt  <= '0;
          end
        end
        RUN: begin
          // A core valid on the last allowed cycle beats the watchdog.
          if (bus.core_data_out_valid) begin
            rsp_dat <= bus.core_data_out;
            rsp_tmo <= 1'b0;
          end else if (run_tmo) begin
            rsp_dat <= '0;
            rsp_tmo <= 1'b1;
          end else begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
        end
        RESP: gap_cnt <= '0;
        GAP:  gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a stand-in core whose ciphertext is data ^ key after a set latency.
module tb_aes_req_arbiter;

  localparam int NR = 4;

  localparam logic [127:0] SJ_DATA = 128'h00000046_00000000_00000000_00000000;
  localparam logic [127:0] SJ_KEY  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] SJ_EXP  = 128'haa2bdb06_bff6a5e8_caa9ba3e_bc1e2acc;

  logic AES_clk;
  logic AES_rst;

  aes_req_arbiter_if #(.N_REQ(NR)) bus ();

  aes_req_arbiter #(
    .N_REQ      (NR),
    .TIMEOUT    (64),
    .GAP_CYCLES (2)
  ) dut (
    .AES_clk (AES_clk),
    .AES_rst (AES_rst),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int           core_lat  = 3;
  bit           core_dead = 1'b0;
  bit           stray_vld = 1'b0;
  int           core_cnt  = 0;
  logic         core_vld  = 1'b0;
  logic [127:0] core_out  = '0;

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    return d ^ k;
  endfunction

  function automatic logic [127:0] slot_data(input int i);
    return {32'hD0D0_0000 | 32'(i), 96'h0};
  endfunction

  function automatic logic [127:0] slot_key(input int i);
    return {96'h0, 32'h0000_5A50 | 32'(i)};
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  // Stand-in AES_top: one-cycle valid pulse core_lat cycles into a job.
  always @(posedge AES_clk) begin
    if (!bus.core_en) begin
      core_cnt <= 0;
      core_vld <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      core_vld <= !core_dead && (core_cnt == core_lat - 1);
      core_out <= core_fn(bus.core_data_in, bus.core_key_in);
    end
  end

  assign bus.core_data_out_valid = core_vld | stray_vld;
  assign bus.core_data_out       = core_out;

  task automatic tick();
    @(negedge AES_clk);
  endtask

  task automatic fill_slots();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[128*i +: 128] = slot_data(i);
      bus.req_key[128*i +: 128]  = slot_key(i);
    end
  endtask

  task automatic do_reset();
    AES_rst       = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    stray_vld     = 1'b0;
    core_dead     = 1'b0;
    core_lat      = 3;
    fill_slots();
    tick();
    tick();
    AES_rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    AES_rst       = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    fill_slots();
    tick();
    tests_run++;
    if (bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
    end
    tests_run++;
    if (bus.core_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_en_valid: got core_en=%b rsp_valid=%b want 0 0", bus.core_en, bus.rsp_valid);
    end
    tests_run++;
    if (bus.core_data_in !== '0 || bus.core_key_in !== '0 || bus.rsp_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_buses: got din=%h key=%h rsp=%h want 0", bus.core_data_in, bus.core_key_in, bus.rsp_data);
    end
    tests_run++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_id_tmo: got id=%0d tmo=%b want 0 0", bus.rsp_id, bus.rsp_timeout);
    end
    bus.req_valid = '0;
    tick();
    AES_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int run_cyc;
    int unstable;
    bit got;
    do_reset();
    bus.req_data[127:0] = SJ_DATA;
    bus.req_key[127:0]  = SJ_KEY;
    bus.req_valid       = 4'b0001;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_ready: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    tests_run++;
    if (bus.core_en !== 1'b1 || bus.core_data_in !== SJ_DATA || bus.core_key_in !== SJ_KEY || bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_run_start: got en=%b din=%h key=%h rdy=%b", bus.core_en, bus.core_data_in, bus.core_key_in, bus.req_ready);
    end
    run_cyc  = 1;
    unstable = 0;
    got      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.core_en === 1'b1) run_cyc++;
      if (bus.core_data_in !== SJ_DATA || bus.core_key_in !== SJ_KEY) unstable++;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL single_rsp_wait: got no rsp_valid in 200 cycles want rsp_valid");
    end
    tests_run++;
    if (run_cyc != 4 || unstable != 0) begin
      tests_failed++;
      $display("FAIL single_run_len: got %0d run cycles (%0d unstable) want 4 (0)", run_cyc, unstable);
    end
    tests_run++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== SJ_EXP || bus.rsp_timeout !== 1'b0 || bus.core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rsp: got id=%0d data=%h tmo=%b en=%b want 0 %h 0 0", bus.rsp_id, bus.rsp_data, bus.rsp_timeout, bus.core_en, SJ_EXP);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.core_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_gap0: got vld=%b en=%b rdy=%b want 0 0 0000", bus.rsp_valid, bus.core_en, bus.req_ready);
    end
    tick();
    tests_run++;
    if (bus.core_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_gap1: got en=%b rdy=%b want 0 0000", bus.core_en, bus.req_ready);
    end
    tick();
    tests_run++;
    if (bus.req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_after_gap: got %b want 0010", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    int exp_id;
    int g;
    bit got;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
`ifdef AES_ARB_PRIORITY_EN
      exp_id = 0;
`else
      exp_id = j % NR;
`endif
      g = -2;
      for (int i = 0; i < 200; i++) begin
        #1;
        if (bus.req_ready !== 4'b0000) begin
          g = onehot_idx(bus.req_ready);
          break;
        end
        tick();
      end
      tests_run++;
      if (g != exp_id) begin
        tests_failed++;
        $display("FAIL fair_grant%0d: got %0d want %0d", j, g, exp_id);
      end
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (bus.rsp_valid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      tests_run++;
      if (!got || bus.rsp_id !== 2'(exp_id) || bus.rsp_data !== core_fn(slot_data(exp_id), slot_key(exp_id))) begin
        tests_failed++;
        $display("FAIL fair_rsp%0d: got vld=%b id=%0d data=%h want id=%0d", j, got, bus.rsp_id, bus.rsp_data, exp_id);
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_dat;
    logic [NR-1:0] exp_next;
    int pulses;
    bit got;
    do_reset();
    exp_dat = core_fn(slot_data(2), slot_key(2));
    bus.req_valid = 4'b0100;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_grant: got %b want 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1011;
    pulses = 0;
    got    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.req_ready !== 4'b0000) pulses++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL bp_rsp_wait: got no rsp_valid in 200 cycles want rsp_valid");
    end
    for (int c = 0; c < 20; c++) begin
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== exp_dat || bus.req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got vld=%b id=%0d data=%h rdy=%b want 1 2 %h 0000", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, exp_dat);
      end
      tick();
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL bp_no_ready: got %0d req_ready pulses want 0", pulses);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got vld=%b en=%b want 0 0", bus.rsp_valid, bus.core_en);
    end
    tick();
    tests_run++;
    if (bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_gap: got %b want 0000", bus.req_ready);
    end
    tick();
`ifdef AES_ARB_PRIORITY_EN
    exp_next = 4'b0001;
`else
    exp_next = 4'b1000;
`endif
    tests_run++;
    if (bus.req_ready !== exp_next) begin
      tests_failed++;
      $display("FAIL bp_next_grant: got %b want %b", bus.req_ready, exp_next);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic run_job(input int id, input logic [NR-1:0] vec, input string tag,
                         output int run_cyc, output bit got);
    bus.req_valid = vec;
    #1;
    tests_run++;
    if (onehot_idx(bus.req_ready) != id) begin
      tests_failed++;
      $display("FAIL %s_grant: got %b want one-hot %0d", tag, bus.req_ready, id);
    end
    tick();
    bus.req_valid = '0;
    run_cyc = 0;
    got     = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.core_en === 1'b1) run_cyc++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int run_cyc;
    bit got;
    do_reset();
    core_dead = 1'b1;
    run_job(0, 4'b0001, "tmo", run_cyc, got);
    tests_run++;
    if (!got || run_cyc != 64) begin
      tests_failed++;
      $display("FAIL tmo_len: got vld=%b after %0d run cycles want 1 after 64", got, run_cyc);
    end
    tests_run++;
    if (bus.rsp_timeout !== 1'b1 || bus.rsp_data !== '0 || bus.core_en !== 1'b0 || bus.rsp_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL tmo_rsp: got tmo=%b data=%h en=%b id=%0d want 1 0 0 0", bus.rsp_timeout, bus.rsp_data, bus.core_en, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    core_dead     = 1'b0;
    tick();
  endtask

  task automatic test_timeout_edge();
    int run_cyc;
    bit got;
    do_reset();
    core_lat = 63;
    run_job(1, 4'b0010, "edge", run_cyc, got);
    tests_run++;
    if (!got || run_cyc != 64) begin
      tests_failed++;
      $display("FAIL edge_len: got vld=%b after %0d run cycles want 1 after 64", got, run_cyc);
    end
    tests_run++;
    if (bus.rsp_timeout !== 1'b0 || bus.rsp_id !== 2'd1 || bus.rsp_data !== core_fn(slot_data(1), slot_key(1))) begin
      tests_failed++;
      $display("FAIL edge_rsp: got tmo=%b id=%0d data=%h want 0 1 %h", bus.rsp_timeout, bus.rsp_id, bus.rsp_data, core_fn(slot_data(1), slot_key(1)));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset();
    core_lat      = 40;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1001;
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (bus.core_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_running: got en=%b want 1", bus.core_en);
    end
    AES_rst = 1'b1;
    #1;
    tests_run++;
    if (bus.core_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rmid_async: got en=%b vld=%b rdy=%b want 0 0 0000", bus.core_en, bus.rsp_valid, bus.req_ready);
    end
    tick();
    tick();
    AES_rst = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rmid_regrant: got %b want 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.core_en !== 1'b0) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++;
      $display("FAIL rmid_stale: got %0d cycles with rsp_valid/core_en want 0", stale);
    end
  endtask

  task automatic test_stray();
    bit got;
    do_reset();
    stray_vld = 1'b1;
    tick();
    stray_vld = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_idle: got vld=%b en=%b want 0 0", bus.rsp_valid, bus.core_en);
    end
    bus.req_valid = 4'b0001;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL stray_idle_grant: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL stray_rsp_wait: got no rsp_valid in 200 cycles want rsp_valid");
    end
    tick();
    bus.rsp_ready = 1'b0;
    stray_vld     = 1'b1;
    tick();
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_gap: got vld=%b en=%b want 0 0", bus.rsp_valid, bus.core_en);
    end
    tick();
    stray_vld     = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL stray_gap_exit: got vld=%b rdy=%b want 0 0010", bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_stray();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by 500000 time units want summary");
    $fatal(1, "simulation time limit reached");
  end

endmodule
